main_mem_arbiter: RTL
=====================

Name: main_mem_arbiter

Overview:
Parametrised shared-memory front end for C cores. It arbitrates memory requests round-robin and sequences each access through an IDLE/WRITE/READ/RESP state machine. It drives an external single-port data RAM with configurable read latency RD_LAT. It also contains an owner-tracking hardware mutex table of LOCKS entries with its own round-robin arbiter. It sits between the core array and the data RAM, and succeeds the fixed-priority 2-core memory/lock block.

Parameters:
C, 2, number of cores (>=2)
AW, 16, memory address width
DW, 16, data width
LOCKS, 1024, mutex entries; LW = $clog2(LOCKS)
RD_LAT, 1, RAM read latency in cycles (1..8)
CW, $clog2(C), core-id width (internal, min 1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
req_valid  in  C  per-core memory request; held with fields stable until req_ready
req_write  in  C  1=write, 0=read
req_adr  in  C*AW  packed, core c at [c*AW +: AW]
req_wdat  in  C*DW  packed write data
req_ready  out  C  one-hot grant, combinational, IDLE only
rsp_valid  out  C  one-hot completion pulse to transaction owner
rsp_dat  out  DW  read data, valid with rsp_valid (0 for writes)
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_adr  out  AW  RAM address (registered)
mem_wdat  out  DW  RAM write data (registered)
mem_rdat  in  DW  RAM read data, valid RD_LAT cycles after first mem_en cycle of a read
lock_en  in  C  lock request; held until lock_ac or lock_err
unlock_en  in  C  unlock request; held until lock_ac or lock_err
lock_adr  in  C*LW  packed mutex index
lock_ac  out  C  one-hot, combinational: lock acquired / unlock accepted
lock_err  out  C  one-hot, combinational: unlock of a free entry, or of an entry owned by another core

Behaviour:
- Reset (async): state=IDLE; mem_rr=0; lock_rr=0; all table entries free; internal regs 0. All outputs 0. An in-flight transaction is dropped and gets no rsp.
- Memory arbitration (IDLE only):
  - Winner w = first c with req_valid[c], scanning from mem_rr upward mod C.
  - req_ready[w]=1 in that cycle.
  - At the edge: latch adr, wdat, write and owner=w; mem_rr<=(w+1)%C; next state WRITE if write, else READ.
  - No request: remain IDLE with outputs 0.
- WRITE (1 cycle): mem_en=1, mem_we=1; rsp_valid[owner]=1, rsp_dat=0; next IDLE.
- READ (RD_LAT cycles, counter 0..RD_LAT-1): mem_en=1, mem_we=0, mem_adr held; at count RD_LAT-1, next RESP.
- RESP (1 cycle): mem_en=0; rsp_valid[owner]=1; rsp_dat=mem_rdat; next IDLE.
- Latencies from grant edge: write ack at +1 cycle; read data at +RD_LAT+1 cycles.
- Throughput: at most one grant per 2 (write) or RD_LAT+2 (read) cycles; req_ready is never asserted outside IDLE.
- Lock unit (independent of memory FSM, one op per cycle):
  - Each entry holds {busy, owner[CW]}.
  - Candidate set = cores with unlock_en. If that set is empty, candidate set = cores with lock_en & !busy[lock_adr[c]].
  - Winner u = first candidate from lock_rr upward mod C; at the edge lock_rr<=(u+1)%C.
  - Unlock by the owner: lock_ac[u]=1; entry freed at edge.
  - Unlock of a free entry or by a non-owner: lock_err[u]=1; no state change; still consumes the slot and advances lock_rr.
  - Lock of a free entry: lock_ac[u]=1; at edge busy=1, owner=u.
  - Lock of a busy entry (including one owned by the requester): no response; requester spins.
  - If unlock_en and lock_en are both set for one core, unlock wins.
- Same-cycle unlock of X and lock of X by another core: only the unlock is processed; the lock is granted in a later cycle.
- All index and rr arithmetic wraps mod C; addresses are not range-checked.

Test Plan:
- C=2, RD_LAT=1: core0 writes 0xBEEF to 0x0010, then reads it -> write: req_ready[0] in cycle T, mem_we=1 with mem_adr=0x0010 at T+1, rsp_valid[0] at T+1. Read: rsp_valid[0] with rsp_dat=0xBEEF two cycles after its grant edge.
- C=4: all cores hold read requests continuously -> grants in order 0,1,2,3,0; no core is granted twice before all others; each grant is followed by exactly one rsp_valid to that core.
- RD_LAT=3: a single read -> mem_en high for 3 cycles with a stable mem_adr; rsp_valid is asserted 4 cycles after the grant edge; no req_ready while the FSM is busy.
- Locks, C=2: core0 locks 5 -> lock_ac[0]. Core1 locks 5 -> spins with no ack. Core1 unlocks 5 -> lock_err[1]. Core0 unlocks 5 -> lock_ac[0], and core1's lock_ac[1] follows in the next cycle.
- Same cycle: core0 unlock_en on 7 (owned by core0) and core1 lock_en on 7 -> lock_ac[0] only; lock_ac[1] the following cycle.
- Reset asserted asynchronously in READ with rsp pending -> all outputs 0 immediately; no rsp_valid after release; lock 5 is free again (the next lock of 5 is acked immediately).

Source files
------------

// File: rtl/main_mem_arbiter.sv
// Shared-memory front end for C cores: round-robin memory arbiter with an
// IDLE/WRITE/READ/RESP access sequencer, plus an owner-tracking mutex table.
module main_mem_arbiter #(
   parameter int C      = 2,
   parameter int AW     = 16,
   parameter int DW     = 16,
   parameter int LOCKS  = 1024,
   parameter int RD_LAT = 1,
   localparam int LW    = $clog2(LOCKS),
   localparam int CW    = (C > 1) ? $clog2(C) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [C-1:0]    req_valid,
   input  logic [C-1:0]    req_write,
   input  logic [C*AW-1:0] req_adr,
   input  logic [C*DW-1:0] req_wdat,
   output logic [C-1:0]    req_ready,
   output logic [C-1:0]    rsp_valid,
   output logic [DW-1:0]   rsp_dat,
   output logic            mem_en,
   output logic            mem_we,
   output logic [AW-1:0]   mem_adr,
   output logic [DW-1:0]   mem_wdat,
   input  logic [DW-1:0]   mem_rdat,
   input  logic [C-1:0]    lock_en,
   input  logic [C-1:0]    unlock_en,
   input  logic [C*LW-1:0] lock_adr,
   output logic [C-1:0]    lock_ac,
   output logic [C-1:0]    lock_err
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   // Returns {found, index} of the first set bit at or after rr, wrapping mod C.
   function automatic logic [CW:0] rr_pick(input logic [C-1:0] cand, input logic [CW-1:0] rr);
      logic [CW:0] res;
      int          idx;
      res = '0;
      for (int i = 0; i < C; i++) begin
         idx = (int'(rr) + i) % C;
         if (!res[CW] && cand[idx]) res = {1'b1, CW'(idx)};
      end
      return res;
   endfunction

   function automatic logic [CW-1:0] rr_next(input logic [CW-1:0] w);
      return CW'((int'(w) + 1) % C);
   endfunction

   function automatic logic [C-1:0] onehot(input logic [CW-1:0] i);
      logic [C-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   state_t        state;
   logic [CW-1:0] mem_rr;
   logic [CW-1:0] owner;
   logic [CW-1:0] mem_win;
   logic [CW:0]   mem_pick;
   logic [2:0]    cnt;

   assign mem_pick  = rr_pick(req_valid, mem_rr);
   assign mem_win   = mem_pick[CW-1:0];
   assign req_ready = (state == IDLE && mem_pick[CW] && !reset) ? onehot(mem_win) : '0;
   assign rsp_dat   = (state == RESP) ? mem_rdat : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         mem_rr    <= '0;
         owner     <= '0;
         cnt       <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_adr   <= '0;
         mem_wdat  <= '0;
         rsp_valid <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_pick[CW]) begin
                  owner     <= mem_win;
                  mem_rr    <= rr_next(mem_win);
                  cnt       <= '0;
                  mem_en    <= 1'b1;
                  mem_we    <= req_write[mem_win];
                  mem_adr   <= req_adr[int'(mem_win)*AW +: AW];
                  mem_wdat  <= req_write[mem_win] ? req_wdat[int'(mem_win)*DW +: DW] : '0;
                  // A write completes in the cycle the RAM sees it.
                  rsp_valid <= req_write[mem_win] ? onehot(mem_win) : '0;
                  state     <= req_write[mem_win] ? WRITE : READ;
               end
            end
            WRITE: begin
               mem_en    <= 1'b0;
               mem_we    <= 1'b0;
               mem_adr   <= '0;
               mem_wdat  <= '0;
               rsp_valid <= '0;
               state     <= IDLE;
            end
            READ: begin
               if (cnt == 3'(RD_LAT - 1)) begin
                  mem_en    <= 1'b0;
                  mem_adr   <= '0;
                  rsp_valid <= onehot(owner);
                  state     <= RESP;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            default: begin
               rsp_valid <= '0;
               state     <= IDLE;
            end
         endcase
      end
   end

   logic [LOCKS-1:0] busy;
   logic [CW-1:0]    owner_tab [LOCKS];
   logic [CW-1:0]    lock_rr;
   logic [CW-1:0]    lk_win;
   logic [CW:0]      lk_pick;
   logic [C-1:0]     lk_free;
   logic [C-1:0]     lk_cand;
   logic [LW-1:0]    lk_adr;
   logic             lk_unl;
   logic             lk_own;

   // Unlocks take the slot whenever any are pending; locks only compete for free entries.
   always_comb begin
      lk_free = '0;
      for (int c = 0; c < C; c++) lk_free[c] = lock_en[c] & ~busy[lock_adr[c*LW +: LW]];
      lk_cand  = (|unlock_en) ? unlock_en : lk_free;
      lk_pick  = rr_pick(lk_cand, lock_rr);
      lk_win   = lk_pick[CW-1:0];
      lk_adr   = lock_adr[int'(lk_win)*LW +: LW];
      lk_unl   = unlock_en[lk_win];
      lk_own   = busy[lk_adr] && (owner_tab[lk_adr] == lk_win);
      lock_ac  = '0;
      lock_err = '0;
      if (lk_pick[CW] && !reset) begin
         if (lk_unl && !lk_own) lock_err = onehot(lk_win);
         else                   lock_ac  = onehot(lk_win);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy    <= '0;
         lock_rr <= '0;
      end else if (lk_pick[CW]) begin
         lock_rr <= rr_next(lk_win);
         if (!lk_unl)     busy[lk_adr] <= 1'b1;
         else if (lk_own) busy[lk_adr] <= 1'b0;
      end
   end

   // Owner field is only meaningful while busy is set, so it needs no reset.
   always_ff @(posedge clk) begin
      if (lk_pick[CW] && !lk_unl && !reset) owner_tab[lk_adr] <= lk_win;
   end

endmodule
